// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointer crossing between the wr_clk and rd_clk domains.
// Flags, levels and error pulses are registered on their own side and are never optimistic.
module async_fifo_gray #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 12,
    parameter int AEMPTY_TH   = 2
) (
    input  logic              wr_clk,
    input  logic              rd_clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              underflow
);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [1:0]                      r_wrst_sync;
    logic [1:0]                      r_rrst_sync;
    logic                            w_wrst_n;
    logic                            w_rrst_n;
    logic [DATA_W-1:0]               r_mem [DEPTH];

    logic [ADDR_W:0]                 r_wptr_bin;
    logic [ADDR_W:0]                 r_wgray;
    logic [SYNC_STAGES-1:0][ADDR_W:0] r_rq_sync;
    logic                            r_full;
    logic                            r_almost_full;
    logic [ADDR_W:0]                 r_wr_level;
    logic                            r_overflow;

    logic [ADDR_W:0]                 r_rptr_bin;
    logic [ADDR_W:0]                 r_rgray;
    logic [SYNC_STAGES-1:0][ADDR_W:0] r_wq_sync;
    logic                            r_empty;
    logic                            r_almost_empty;
    logic [ADDR_W:0]                 r_rd_level;
    logic                            r_underflow;
    logic [DATA_W-1:0]               r_rd_data;
    logic                            r_rd_valid;

    logic                            w_wr_accept;
    logic [ADDR_W:0]                 w_wptr_next;
    logic [ADDR_W:0]                 w_wgray_next;
    logic [ADDR_W:0]                 w_rq;
    logic [ADDR_W:0]                 w_wr_level_next;
    logic                            w_full_next;
    logic                            w_rd_accept;
    logic [ADDR_W:0]                 w_rptr_next;
    logic [ADDR_W:0]                 w_rgray_next;
    logic [ADDR_W:0]                 w_wq;
    logic [ADDR_W:0]                 w_rd_level_next;
    logic                            w_empty_next;

    // Per-domain reset: asserts asynchronously, releases after two local clock edges.
    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) r_wrst_sync <= 2'b00;
        else          r_wrst_sync <= {r_wrst_sync[0], 1'b1};
    end

    // Read-domain counterpart of the reset release synchronizer.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) r_rrst_sync <= 2'b00;
        else          r_rrst_sync <= {r_rrst_sync[0], 1'b1};
    end

    assign w_wrst_n = r_wrst_sync[1];
    assign w_rrst_n = r_rrst_sync[1];

    // Write side next-state: flags are derived from the post-increment pointer so they land on the accepting edge.
    assign w_wr_accept     = wr_en & ~r_full;
    assign w_wptr_next     = r_wptr_bin + {{ADDR_W{1'b0}}, w_wr_accept};
    assign w_wgray_next    = bin2gray(w_wptr_next);
    assign w_rq            = r_rq_sync[SYNC_STAGES-1];
    assign w_full_next     = (w_wgray_next == {~w_rq[ADDR_W:ADDR_W-1], w_rq[ADDR_W-2:0]});
    assign w_wr_level_next = w_wptr_next - gray2bin(w_rq);

    // Storage array, written only from the write domain and deliberately left unreset.
    always_ff @(posedge wr_clk) begin
        if (w_wr_accept) r_mem[r_wptr_bin[ADDR_W-1:0]] <= wr_data;
    end

    // Write pointer, read-pointer synchronizer and write-side status registers.
    always_ff @(posedge wr_clk or negedge w_wrst_n) begin
        if (!w_wrst_n) begin
            r_wptr_bin    <= '0;
            r_wgray       <= '0;
            r_rq_sync     <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_wptr_bin    <= w_wptr_next;
            r_wgray       <= w_wgray_next;
            r_rq_sync     <= {r_rq_sync[SYNC_STAGES-2:0], r_rgray};
            r_full        <= w_full_next;
            r_almost_full <= (w_wr_level_next >= AFULL_LV);
            r_wr_level    <= w_wr_level_next;
            r_overflow    <= wr_en & r_full;
        end
    end

    // Read side next-state mirrors the write side against the synchronized write pointer.
    assign w_rd_accept     = rd_en & ~r_empty;
    assign w_rptr_next     = r_rptr_bin + {{ADDR_W{1'b0}}, w_rd_accept};
    assign w_rgray_next    = bin2gray(w_rptr_next);
    assign w_wq            = r_wq_sync[SYNC_STAGES-1];
    assign w_empty_next    = (w_rgray_next == w_wq);
    assign w_rd_level_next = gray2bin(w_wq) - w_rptr_next;

    // Read pointer, write-pointer synchronizer, data register and read-side status registers.
    always_ff @(posedge rd_clk or negedge w_rrst_n) begin
        if (!w_rrst_n) begin
            r_rptr_bin     <= '0;
            r_rgray        <= '0;
            r_wq_sync      <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_level     <= '0;
            r_underflow    <= 1'b0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
        end else begin
            r_rptr_bin     <= w_rptr_next;
            r_rgray        <= w_rgray_next;
            r_wq_sync      <= {r_wq_sync[SYNC_STAGES-2:0], r_wgray};
            r_empty        <= w_empty_next;
            r_almost_empty <= (w_rd_level_next <= AEMPTY_LV);
            r_rd_level     <= w_rd_level_next;
            r_underflow    <= rd_en & r_empty;
            r_rd_valid     <= w_rd_accept;
            if (w_rd_accept) r_rd_data <= r_mem[r_rptr_bin[ADDR_W-1:0]];
        end
    end

    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign wr_level     = r_wr_level;
    assign overflow     = r_overflow;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_level     = r_rd_level;
    assign underflow    = r_underflow;
endmodule

// File: doc/async_fifo_gray.md
# async_fifo_gray

Parametrised dual-clock FIFO for the AXIL–SDRAM interface. It carries multi-bit words between the AXI-Lite clock domain (wr_clk) and the SDRAM controller domain (rd_clk). Pointers cross domains as Gray code through configurable synchronizer chains. Each side gets registered full/empty, programmable almost-full/almost-empty, fill-level counts and overflow/underflow error pulses.

## Interface
- DATA_W, 32, word width in bits
- ADDR_W, 4, address bits; depth = 2^ADDR_W (power of two only, ADDR_W ≥ 2)
- SYNC_STAGES, 2, flops per pointer synchronizer (≥ 2)
- AFULL_TH, 12, almost_full asserts when wr_level ≥ AFULL_TH
- AEMPTY_TH, 2, almost_empty asserts when rd_level ≤ AEMPTY_TH
- wr_clk  in  1  write-domain clock
- rd_clk  in  1  read-domain clock
- reset_n  in  1  reset for both domains; reset reset_n, asynchronous, active-low; clock wr_clk
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- full  out  1  no free entry (wr_clk domain)
- almost_full  out  1  threshold flag (wr_clk)
- wr_level  out  ADDR_W+1  conservative occupancy seen by the writer
- overflow  out  1  one-cycle pulse: wr_en while full
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  one-cycle pulse: rd_data updated
- empty  out  1  no readable entry (rd_clk domain)
- almost_empty  out  1  threshold flag (rd_clk)
- rd_level  out  ADDR_W+1  conservative occupancy seen by the reader
- underflow  out  1  one-cycle pulse: rd_en while empty

## Operation
- Storage is a 2^ADDR_W × DATA_W array, written on wr_clk only and not reset.
- Each side keeps an (ADDR_W+1)-bit binary pointer and a registered Gray copy (g = b ^ (b>>1)). The MSB is the wrap bit.
- Write is accepted when wr_en && !full: mem[wptr[ADDR_W-1:0]] ← wr_data, wptr += 1.
- Read is accepted when rd_en && !empty: rd_data ← mem[rptr[ADDR_W-1:0]], rptr += 1, rd_valid = 1 next cycle.
- Cross-domain transfer:
  - wgray passes through SYNC_STAGES rd_clk flops to give wq.
  - rgray passes through SYNC_STAGES wr_clk flops to give rq.
  - Synchronized Gray values are converted back to binary in the destination domain.
- Flags are registered and computed from the next pointer values:
  - full_next = (wgray_next == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]})
  - empty_next = (rgray_next == wq)
- Levels:
  - wr_level = wptr − bin(rq)
  - rd_level = bin(wq) − rptr
  - Both use modulo 2^(ADDR_W+1) arithmetic and range 0..2^ADDR_W.
- Rejected requests:
  - wr_en at full: data dropped, pointer unchanged, overflow pulses for 1 cycle.
  - rd_en at empty: underflow pulses for 1 cycle; rd_data holds; rd_valid stays 0.
- Pointer wrap past 2^(ADDR_W+1)−1 to 0 is seamless; full/empty stay correct across it.
- Simultaneous read and write in different domains need no arbitration. full and empty are pessimistic, never optimistic.
- Reset is asserted asynchronously and deasserted through a 2-flop synchronizer per domain. Reset in the middle of traffic discards all contents.

## Timing
- Reset values: full=0, almost_full=0, wr_level=0, overflow=0, rd_data=0, rd_valid=0, empty=1, almost_empty=1, rd_level=0, underflow=0. All pointers and synchronizers clear to 0.
- full asserts on the same wr_clk edge that accepts the write filling the last entry.
- empty asserts on the same rd_clk edge that accepts the read of the last entry.
- Read latency: rd_data and rd_valid appear 1 rd_clk cycle after the accepting edge.
- First write into an empty FIFO: empty deasserts SYNC_STAGES+1 rd_clk edges after the write edge (+1 edge for wgray registration uncertainty).
- full deasserts SYNC_STAGES+1 wr_clk edges after the freeing read.
- wr_level and rd_level follow the same synchronizer delays. almost_* flags are registered from the *_level_next values.
- No combinational path exists from any input to any output.

## Test plan
- Reset and fill, DATA_W=8, ADDR_W=4, wr_clk 100 MHz, rd_clk 37 MHz:
  - Under reset, all outputs hold their reset values with empty=1.
  - Write 0x00..0x0F: full=1 on the 16th write edge; almost_full=1 from the 12th write.
- Overflow: after the fill above, write 0xAA -> overflow pulses for 1 wr_clk cycle, wr_level=16. Draining returns 0x00..0x0F in order; 0xAA never appears.
- Underflow: empty FIFO, rd_en=1 -> underflow pulses, rd_valid=0, rd_data unchanged. A single write of 0x5C -> empty=0 within 4 rd_clk edges; a read then returns 0x5C with a rd_valid pulse.
- Wrap: stream 100 words with an incrementing pattern, rd_en random at 60% -> data in order, no overflow or underflow, pointer wraps at least 3 times.
- Mid-traffic reset: assert reset_n=0 for 3 ns during streaming -> all flags return to reset values immediately. After release, 4 new words read back correctly with no stale data.
- Clock-ratio sweep: rd_clk/wr_clk ∈ {0.3, 1.0, 3.1} with random enables -> scoreboard match and wr_level ≤ 16. empty and full are never observed while a word is readable or a slot is free, respectively, beyond the SYNC_STAGES+1 window.
